// File: rtl/y0_dwa_driver.sv
// Converts 4-level anti-noise codes into DWA-rotated thermometer drive for an
// N_EL-element unit DAC, with stall detection, a zero-mean mute pattern and illegal-code flagging.
module y0_dwa_driver #(
    parameter int unsigned IN_W    = 8,
    parameter int unsigned N_EL    = 3,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            y0_valid_in,
    input  logic [IN_W-1:0] y0_data_in,
    output logic [N_EL-1:0] el_out,
    output logic            el_valid_out,
    output logic            muted,
    output logic            err_out,
    output logic            err_sticky,
    output logic [7:0]      err_cnt
);

    localparam int unsigned PW = (N_EL > 2) ? $clog2(N_EL) : 1;
    localparam int unsigned KW = $clog2(N_EL + 1);
    localparam int unsigned SW = $clog2(2 * N_EL);
    localparam int unsigned CW = $clog2(TIMEOUT);

    localparam logic [N_EL-1:0] ALL1 = '1;
    localparam logic [N_EL-1:0] LO   = ~(ALL1 << ((N_EL - 1) / 2));
    localparam logic [N_EL-1:0] HI   = ~(ALL1 << ((N_EL + 1) / 2));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_MUTE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   p_q, p_d;
    logic [N_EL-1:0] el_q, el_d;
    logic            el_valid_q, el_valid_d;
    logic            muted_q, muted_d;
    logic            err_out_q, err_out_d;
    logic            err_sticky_q, err_sticky_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [CW-1:0]   idle_q, idle_d;
    logic            phase_q, phase_d;

    int                  half;
    logic                code_ok;
    logic [KW-1:0]       k;
    logic [N_EL-1:0]     mask;
    logic [2*N_EL-1:0]   dbl;
    logic [N_EL-1:0]     therm;
    logic [SW-1:0]       sum;
    logic [PW-1:0]       p_next;

    // Decode: legal codes are 2 mod 4 with |code/2| <= N_EL, k = (code/2 + N_EL)/2
    always_comb begin
        half    = int'($signed(y0_data_in)) >>> 1;
        code_ok = (y0_data_in[1:0] == 2'b10) && (half >= -int'(N_EL)) && (half <= int'(N_EL));
        k       = KW'((half + int'(N_EL)) >>> 1);
    end

    // k ones starting at pointer p, wrapping via a double-width rotate
    always_comb begin
        mask   = ~(ALL1 << k);
        dbl    = {{N_EL{1'b0}}, mask} << p_q;
        therm  = dbl[N_EL-1:0] | dbl[2*N_EL-1:N_EL];
        sum    = SW'(p_q) + SW'(k);
        p_next = (sum >= SW'(N_EL)) ? PW'(sum - SW'(N_EL)) : PW'(sum);
    end

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        el_d         = el_q;
        el_valid_d   = 1'b0;
        err_out_d    = 1'b0;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        idle_d       = idle_q;
        phase_d      = phase_q;

        if (y0_valid_in) begin
            // A sample is processed identically whatever the current state
            state_d    = S_RUN;
            idle_d     = '0;
            el_valid_d = 1'b1;
            if (code_ok) begin
                el_d = therm;
                p_d  = p_next;
            end else begin
                err_out_d    = 1'b1;
                err_sticky_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (idle_q == CW'(TIMEOUT - 1)) begin
                        state_d = S_MUTE;
                        idle_d  = '0;
                        el_d    = LO;
                        phase_d = 1'b1;
                    end else begin
                        idle_d = idle_q + CW'(1);
                    end
                end
                default: begin
                    el_d    = phase_q ? HI : LO;
                    phase_d = ~phase_q;
                end
            endcase
        end

        muted_d = (state_d != S_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            p_q          <= '0;
            el_q         <= LO;
            el_valid_q   <= 1'b0;
            muted_q      <= 1'b1;
            err_out_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            idle_q       <= '0;
            phase_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            el_q         <= el_d;
            el_valid_q   <= el_valid_d;
            muted_q      <= muted_d;
            err_out_q    <= err_out_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            idle_q       <= idle_d;
            phase_q      <= phase_d;
        end
    end

    assign el_out       = el_q;
    assign el_valid_out = el_valid_q;
    assign muted        = muted_q;
    assign err_out      = err_out_q;
    assign err_sticky   = err_sticky_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_y0_dwa_driver.sv
// Directed bench for y0_dwa_driver: a cycle-level behavioural model checked every cycle,
// plus hand-computed literal expectations at the interesting points.
module tb_y0_dwa_driver;

    localparam int unsigned IN_W    = 8;
    localparam int unsigned N_EL    = 3;
    localparam int unsigned TIMEOUT = 64;
    localparam int          LO      = 1;   // 3'b001
    localparam int          HI      = 3;   // 3'b011

    logic            clock;
    logic            reset;
    logic            y0_valid_in;
    logic [IN_W-1:0] y0_data_in;
    logic [N_EL-1:0] el_out;
    logic            el_valid_out;
    logic            muted;
    logic            err_out;
    logic            err_sticky;
    logic [7:0]      err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    bit m_run, m_phase, m_elv, m_err, m_sticky;
    int m_since, m_p, m_el, m_cnt;

    y0_dwa_driver #(.IN_W(IN_W), .N_EL(N_EL), .TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .y0_valid_in (y0_valid_in),
        .y0_data_in  (y0_data_in),
        .el_out      (el_out),
        .el_valid_out(el_valid_out),
        .muted       (muted),
        .err_out     (err_out),
        .err_sticky  (err_sticky),
        .err_cnt     (err_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int code_k(input int d);
        case (d)
            -6:      return 0;
            -2:      return 1;
            2:       return 2;
            6:       return 3;
            default: return -1;
        endcase
    endfunction

    // k consecutive ones starting at bit p, wrapping around N_EL bits
    function automatic int rot_el(input int k, input int p);
        int m;
        m = (1 << k) - 1;
        return ((m << p) | (m >> (int'(N_EL) - p))) & ((1 << N_EL) - 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        int k;
        if (reset) begin
            m_run = 0; m_since = 0; m_phase = 0; m_p = 0; m_el = LO;
            m_elv = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
        end else begin
            m_elv = 0;
            m_err = 0;
            if (y0_valid_in) begin
                k = code_k(int'($signed(y0_data_in)));
                m_run = 1; m_since = 0; m_elv = 1;
                if (k < 0) begin
                    m_err = 1; m_sticky = 1;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    m_el = rot_el(k, m_p);
                    m_p  = (m_p + k) % int'(N_EL);
                end
            end else if (m_run) begin
                m_since++;
                if (m_since == int'(TIMEOUT)) begin
                    m_run = 0; m_phase = 0;
                    m_el = m_phase ? HI : LO;
                    m_phase = !m_phase;
                end
            end else begin
                m_el = m_phase ? HI : LO;
                m_phase = !m_phase;
            end
        end
    endtask

    task automatic compare_all();
        chk("model el_out",       32'(el_out),       32'(m_el));
        chk("model el_valid_out", 32'(el_valid_out), 32'(m_elv));
        chk("model muted",        32'(muted),        32'(!m_run));
        chk("model err_out",      32'(err_out),      32'(m_err));
        chk("model err_sticky",   32'(err_sticky),   32'(m_sticky));
        chk("model err_cnt",      32'(err_cnt),      32'(m_cnt));
    endtask

    // Apply one cycle of input, advance the model at the edge, compare at the falling edge
    task automatic drive(input logic v, input int d, input logic r);
        y0_valid_in = v;
        y0_data_in  = IN_W'(d);
        reset       = r;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    int          dwa_in  [6] = '{2, 6, -2, 2, 2, -6};
    logic [2:0]  dwa_exp [6] = '{3'b011, 3'b111, 3'b100, 3'b011, 3'b101, 3'b000};

    initial begin
        reset = 1'b1; y0_valid_in = 1'b0; y0_data_in = '0;

        // Reset and idle pattern
        repeat (3) drive(0, 0, 1);
        chk("rst el_out", 32'(el_out), 32'h1);
        chk("rst muted", 32'(muted), 32'h1);
        chk("rst err_sticky", 32'(err_sticky), 32'h0);
        chk("rst err_cnt", 32'(err_cnt), 32'h0);
        drive(0, 0, 0); chk("idle el 0", 32'(el_out), 32'h1);
        drive(0, 0, 0); chk("idle el 1", 32'(el_out), 32'h3);
        drive(0, 0, 0); chk("idle el 2", 32'(el_out), 32'h1);

        // DWA rotation and wrap on consecutive samples
        for (int i = 0; i < 6; i++) begin
            drive(1, dwa_in[i], 0);
            chk($sformatf("dwa el %0d", i), 32'(el_out), 32'(dwa_exp[i]));
            chk($sformatf("dwa valid %0d", i), 32'(el_valid_out), 32'h1);
            chk($sformatf("dwa muted %0d", i), 32'(muted), 32'h0);
        end
        chk("dwa model p", 32'(m_p), 32'd1);

        // Timeout A: single valid, muted rises TIMEOUT+1 cycles later
        drive(1, 2, 0); chk("toA el", 32'(el_out), 32'h6);
        repeat (TIMEOUT - 1) drive(0, 0, 0);
        chk("toA muted before", 32'(muted), 32'h0);
        drive(0, 0, 0);
        chk("toA muted rise", 32'(muted), 32'h1);
        chk("toA first LO", 32'(el_out), 32'h1);
        drive(0, 0, 0); chk("toA HI", 32'(el_out), 32'h3);

        // Timeout B: second valid at cycle 63 restarts the count
        drive(1, -2, 0); chk("toB el0", 32'(el_out), 32'h1);
        repeat (62) drive(0, 0, 0);
        drive(1, 2, 0); chk("toB el63", 32'(el_out), 32'h6);
        chk("toB muted63", 32'(muted), 32'h0);
        repeat (TIMEOUT - 1) drive(0, 0, 0);
        chk("toB muted127", 32'(muted), 32'h0);
        drive(0, 0, 0); chk("toB muted128", 32'(muted), 32'h1);

        // Valid in the exact cycle the counter hits TIMEOUT-1 keeps RUN
        drive(1, -2, 0); chk("toC el0", 32'(el_out), 32'h1);
        repeat (TIMEOUT - 1) drive(0, 0, 0);
        drive(1, -2, 0);
        chk("toC el edge", 32'(el_out), 32'h2);
        chk("toC muted edge", 32'(muted), 32'h0);
        drive(0, 0, 0); chk("toC muted after", 32'(muted), 32'h0);

        // Mute with p=2, then resume
        repeat (TIMEOUT - 1) drive(0, 0, 0);
        chk("mute entered", 32'(muted), 32'h1);
        repeat (3) drive(0, 0, 0);
        chk("mute pattern", 32'(el_out), 32'h3);
        drive(1, -2, 0);
        chk("resume el", 32'(el_out), 32'h4);
        chk("resume muted", 32'(muted), 32'h0);
        chk("resume valid", 32'(el_valid_out), 32'h1);

        // Illegal codes
        drive(1, 2, 0); chk("ill pre el", 32'(el_out), 32'h3);
        drive(1, 0, 0);
        chk("ill0 el", 32'(el_out), 32'h3);
        chk("ill0 err_out", 32'(err_out), 32'h1);
        chk("ill0 sticky", 32'(err_sticky), 32'h1);
        chk("ill0 cnt", 32'(err_cnt), 32'd1);
        drive(1, 4, 0);
        chk("ill4 cnt", 32'(err_cnt), 32'd2);
        repeat (256) drive(1, -1, 0);
        chk("ill sat cnt", 32'(err_cnt), 32'd255);
        chk("ill sat el", 32'(el_out), 32'h3);
        drive(1, 10, 0);
        drive(1, -10, 0);
        drive(1, -126, 0);
        chk("ill range err_out", 32'(err_out), 32'h1);
        drive(1, 6, 0);
        chk("ill after el", 32'(el_out), 32'h7);
        chk("ill after err_out", 32'(err_out), 32'h0);
        chk("ill after cnt", 32'(err_cnt), 32'd255);

        // Reset mid-stream, with a valid present during reset
        drive(1, 2, 0); chk("mid el", 32'(el_out), 32'h5);
        drive(1, 6, 1);
        chk("mid rst el", 32'(el_out), 32'h1);
        chk("mid rst valid", 32'(el_valid_out), 32'h0);
        chk("mid rst muted", 32'(muted), 32'h1);
        chk("mid rst cnt", 32'(err_cnt), 32'h0);
        drive(1, 2, 0);
        chk("mid post el", 32'(el_out), 32'h3);
        chk("mid post muted", 32'(muted), 32'h0);
        drive(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
